// File: rtl/fetch_pkg.sv
// fetch_pkg: shared entry type, widths and constants for
// the instruction fetch queue and its FIFO.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;
  localparam int PC_STEP = 4;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular buffer of fetch entries with push,
// pop and flush; pointers wrap modulo DEPTH.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      push_i,
  input  fetch_entry_t              data_i,
  input  logic                      pop_i,
  input  logic                      flush_i,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [cnt_w(DEPTH)-1:0]   count_o,
  output fetch_entry_t              head_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = cnt_w(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  fetch_entry_t    mem_q [DEPTH];
  logic [PW-1:0]   rd_q;
  logic [PW-1:0]   wr_q;
  logic [CW-1:0]   cnt_q;
  logic            do_pop;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '{pc: '0, instr: NOP_INSTR};
      end
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= nxt(wr_q);
      end
      if (do_pop) begin
        rd_q <= nxt(rd_q);
      end
      cnt_q <= cnt_q + CW'(push_i) - CW'(do_pop);
    end
  end

  // Credit accounting upstream keeps this from ever firing.
  a_no_overflow: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    !(push_i && full_o && !do_pop && !flush_i)
  );

endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: sequential fetch with in-order buffer.
// Optional FETCH_PERF_EN adds stall/flush counters.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                QDEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  pc_out
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_stall_cnt,
  output logic [31:0]        perf_flush_cnt
`endif
);

  localparam int CW = cnt_w(QDEPTH);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [ADDR_W-1:0] redir_pc;
  logic [CW-1:0]     out_q, out_d;
  logic [CW-1:0]     drop_q, drop_d;
  logic [CW-1:0]     count;
  logic              rsp, push, pop;
  logic              full, empty;
  logic              unused_bits;
  fetch_entry_t      wr_entry, head;

  assign redir_pc = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign unused_bits = ^{redirect_pc[1:0], full};

  // Stray beats with nothing in flight (e.g. after reset) are ignored.
  assign rsp  = imem_rvalid && (out_q != '0);
  assign push = rsp && !redirect_valid && (drop_q == '0);

  assign instr_valid = !empty;
  assign pop = instr_valid && !stall && !redirect_valid;

  assign imem_req = rst_n && !redirect_valid &&
    (({1'b0, count} + {1'b0, out_q}) < (CW+1)'(QDEPTH));
  assign imem_addr = rst_n ? fetch_pc_q : '0;

  assign instr_out = instr_valid ? head.instr : '0;
  assign pc_out    = instr_valid ? ADDR_W'(head.pc) : '0;
  assign wr_entry  = '{pc: PC_W'(resp_pc_q), instr: imem_rdata};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    out_d      = out_q - CW'(rsp);
    if (redirect_valid) begin
      fetch_pc_d = redir_pc;
      resp_pc_d  = redir_pc;
      drop_d     = out_d;
    end else begin
      if (imem_req) begin
        fetch_pc_d = fetch_pc_q + STEP;
        out_d      = out_d + CW'(1);
      end
      if (rsp && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
      if (push) begin
        resp_pc_d = resp_pc_q + STEP;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .data_i  (wr_entry),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count),
    .head_o  (head)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (instr_valid && stall) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (redirect_valid) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: random stimulus, in-order memory model
// and a scoreboard of the expected instruction stream.
module tb_instr_fetch_queue;

  localparam int QD = 3;
  localparam logic [31:0] RPC = 32'hFFFF_FFF8;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rd_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int lat_lo = 1;
  int lat_hi = 1;
  int last_due = 0;
  int idle = 0;
  int n_stall = 0;
  int n_flush = 0;

  exp_t        exp_q[$];
  rd_t         pend[$];
  logic [31:0] model_pc = RPC;
  logic [31:0] exp_fetch = RPC;
  logic        prev_redir = 1'b0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_pc = '0;
  logic [31:0] prev_ins = '0;

  instr_fetch_queue #(
    .ADDR_W   (32),
    .RESET_PC (RPC),
    .QDEPTH   (QD)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_out      (instr_out),
    .pc_out         (pc_out)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Memory: capture accepted requests, return words in order.
  always @(negedge clk) begin
    int d;
    #1;
    if (rst_n && imem_req) begin
      d = cyc + $urandom_range(lat_hi, lat_lo);
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      pend.push_back('{imem_addr, d});
    end
  end

  always @(posedge clk) begin
    rd_t r;
    #1;
    if (!rst_n) begin
      pend.delete();
      last_due = 0;
      imem_rvalid = 1'b0;
      imem_rdata = '0;
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      r = pend.pop_front();
      imem_rvalid = 1'b1;
      imem_rdata = memf(r.addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata = $urandom;
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      check(!imem_req && !instr_valid, "rst_ctrl",
            {30'd0, imem_req, instr_valid}, 32'd0);
      check(imem_addr == 0 && instr_out == 0 && pc_out == 0,
            "rst_data", imem_addr | instr_out | pc_out, 32'd0);
`ifdef FETCH_PERF_EN
      check(perf_stall_cnt == 0 && perf_flush_cnt == 0,
            "rst_perf", perf_stall_cnt | perf_flush_cnt, 32'd0);
`endif
      exp_fetch = RPC;
      prev_redir = 1'b0;
      prev_hold = 1'b0;
      idle = 0;
      n_stall = 0;
      n_flush = 0;
    end else begin
      check(pend.size() + int'(imem_rvalid) <= QD, "outstanding",
            32'(pend.size()), 32'(QD));
      if (imem_req) begin
        check(!redirect_valid, "req_in_redirect", 32'd1, 32'd0);
        check(imem_addr == exp_fetch, "fetch_addr",
              imem_addr, exp_fetch);
        exp_fetch = exp_fetch + 32'd4;
      end
      if (redirect_valid) exp_fetch = {redirect_pc[31:2], 2'b00};
      if (!instr_valid) begin
        check(instr_out == 0, "idle_instr", instr_out, 32'd0);
        check(pc_out == 0, "idle_pc", pc_out, 32'd0);
      end
      if (prev_redir)
        check(!instr_valid, "flush_empty", {31'd0, instr_valid}, 32'd0);
      if (prev_hold) begin
        check(instr_valid && pc_out == prev_pc, "stall_pc",
              pc_out, prev_pc);
        check(instr_out == prev_ins, "stall_instr",
              instr_out, prev_ins);
      end
      if (instr_valid && !stall && !redirect_valid) begin
        check(exp_q.size() > 0, "sb_underflow", pc_out, 32'd0);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check(pc_out == e.pc, "pc_out", pc_out, e.pc);
          check(instr_out == e.ins, "instr_out", instr_out, e.ins);
        end
        idle = 0;
      end else if (!stall && !redirect_valid) begin
        idle++;
        check(idle <= 30, "starve", 32'(idle), 32'd30);
        if (idle > 30) idle = 0;
      end else begin
        idle = 0;
      end
      if (instr_valid && stall) n_stall++;
      if (redirect_valid) n_flush++;
      prev_redir = redirect_valid;
      prev_hold = instr_valid && stall && !redirect_valid;
      prev_pc = pc_out;
      prev_ins = instr_out;
    end
  end

  // Drive inputs and extend the expected stream from the model PC.
  task automatic apply(input logic st, input logic rd,
                       input logic [31:0] tgt);
    stall = st;
    redirect_valid = rd;
    redirect_pc = rd ? tgt : $urandom;
    if (rd) begin
      exp_q.delete();
      model_pc = tgt & ~32'h3;
    end
    while (exp_q.size() < 16) begin
      exp_q.push_back('{model_pc, memf(model_pc)});
      model_pc = model_pc + 32'd4;
    end
  endtask

  task automatic step(input logic st, input logic rd,
                      input logic [31:0] tgt);
    @(posedge clk);
    #2;
    apply(st, rd, tgt);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    model_pc = RPC;
    apply(1'b0, 1'b0, 32'd0);
    repeat (n) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    bit found;
    lat_lo = 1;
    lat_hi = 1;
    do_reset(4);
    // Fill latency: nothing visible until the third cycle.
    @(negedge clk);
    check(!instr_valid, "fill_c0", {31'd0, instr_valid}, 32'd0);
    @(negedge clk);
    check(!instr_valid, "fill_c1", {31'd0, instr_valid}, 32'd0);
    @(negedge clk);
    check(instr_valid && pc_out == RPC, "fill_c2", pc_out, RPC);
    repeat (20) step(1'b0, 1'b0, 32'd0);
    repeat (5) step(1'b1, 1'b0, 32'd0);
    repeat (10) step(1'b0, 1'b0, 32'd0);

    lat_lo = 3;
    lat_hi = 3;
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(posedge clk);
      #2;
      if (pend.size() >= 2) begin
        apply(1'b0, 1'b1, 32'h0000_0102);
        found = 1'b1;
      end else begin
        apply(1'b0, 1'b0, 32'd0);
      end
    end
    check(found, "wait_two_out", {31'd0, found}, 32'd1);
    repeat (15) step(1'b0, 1'b0, 32'd0);

    lat_lo = 1;
    lat_hi = 1;
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(posedge clk);
      #2;
      if (imem_rvalid && instr_valid) begin
        apply(1'b1, 1'b1, $urandom);
        found = 1'b1;
      end else begin
        apply(1'b0, 1'b0, 32'd0);
      end
    end
    check(found, "wait_rsp_redir", {31'd0, found}, 32'd1);
    repeat (10) step(1'b0, 1'b0, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) lat_hi = $urandom_range(4, 1);
      if (i == 1500) do_reset(3);
      step($urandom_range(9, 0) < 3, $urandom_range(99, 0) < 3,
           $urandom);
    end
    step(1'b0, 1'b0, 32'd0);
`ifdef FETCH_PERF_EN
    check(perf_stall_cnt == n_stall, "perf_stall",
          perf_stall_cnt, 32'(n_stall));
    check(perf_flush_cnt == n_flush, "perf_flush",
          perf_flush_cnt, 32'(n_flush));
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
